// File: rtl/jstk_spi_responder_if.sv
// SPI link between a joystick initiator (master) and the PmodJSTK responder (slave).
`timescale 1ns/1ps
interface jstk_spi_responder_if;
    logic ss;
    logic sclk;
    logic mosi;
    logic miso;
    logic miso_oe;

    modport master (output ss, sclk, mosi, input miso, miso_oe);
    modport slave  (input ss, sclk, mosi, output miso, miso_oe);
endinterface

// File: rtl/jstk_spi_responder.sv
// SPI mode-0 responder emulating a PmodJSTK: returns a snapshot of x/y/buttons, captures the LED command.
// Optional JSTK_RESP_ERRCNT_EN: adds err_cnt output and returns 8'hFF for overrun bytes.
`timescale 1ns/1ps
module jstk_spi_responder #(
    parameter int NBYTES      = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    jstk_spi_responder_if.slave    spi,
    input  logic [9:0]             x_pos,
    input  logic [9:0]             y_pos,
    input  logic [2:0]             btn,
    output logic [1:0]             led,
    output logic                   frame_done,
`ifdef JSTK_RESP_ERRCNT_EN
    output logic                   frame_err,
    output logic [7:0]             err_cnt
`else
    output logic                   frame_err
`endif
);

`ifdef JSTK_RESP_ERRCNT_EN
    localparam logic [7:0] FILL_BYTE = 8'hFF;
`else
    localparam logic [7:0] FILL_BYTE = 8'h00;
`endif

    typedef enum logic [1:0] {S_IDLE, S_ACTIVE, S_OVER} state_t;

    state_t                 r_state, w_state_nx;
    logic [SYNC_STAGES-1:0] r_ss_sync, r_sclk_sync, r_mosi_sync;
    logic                   r_ss_d, r_sclk_d;
    logic [22:0]            r_snap;
    logic [7:0]             r_tx, r_rx;
    logic [3:0]             r_bit_cnt, r_byte_cnt;
    logic                   r_miso, r_miso_oe, r_frame_done, r_frame_err;
    logic [1:0]             r_led;
    logic                   w_ss, w_sclk, w_mosi;
    logic                   w_ss_rise, w_ss_fall, w_sclk_rise, w_sclk_fall;
    logic                   w_shift, w_byte_done, w_pulse_done, w_pulse_err;
    logic [7:0]             w_tx_next;

    // snapshot layout: {x[9:0], y[9:0], btn[2:0]}
    function automatic logic [7:0] frame_byte(input logic [22:0] snap, input logic [3:0] idx);
        case (idx)
            4'd0:    frame_byte = snap[20:13];
            4'd1:    frame_byte = {6'b0, snap[22:21]};
            4'd2:    frame_byte = snap[10:3];
            4'd3:    frame_byte = {6'b0, snap[12:11]};
            4'd4:    frame_byte = {5'b0, snap[2:0]};
            default: frame_byte = 8'h00;
        endcase
    endfunction

    assign w_ss   = r_ss_sync[SYNC_STAGES-1];
    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];

    // sclk edges only count while ss is low, so a concurrent ss rise always wins
    assign w_ss_rise   = w_ss & ~r_ss_d;
    assign w_ss_fall   = ~w_ss & r_ss_d;
    assign w_sclk_rise = w_sclk & ~r_sclk_d & ~w_ss & (r_state != S_IDLE);
    assign w_sclk_fall = ~w_sclk & r_sclk_d & ~w_ss & (r_state != S_IDLE);
    assign w_byte_done = w_sclk_fall & (r_bit_cnt == 4'd8);
    assign w_shift     = w_sclk_fall & (r_bit_cnt != 4'd0) & (r_bit_cnt != 4'd8);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        if (w_ss_rise) begin
            w_state_nx = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:   if (w_ss_fall) w_state_nx = S_ACTIVE;
                S_ACTIVE: if (w_byte_done && r_byte_cnt == 4'(NBYTES-1)) w_state_nx = S_OVER;
                default:  w_state_nx = r_state;
            endcase
        end
    end

    always_comb begin
        w_pulse_done = w_ss_rise & (r_bit_cnt == 4'd0) & (r_byte_cnt == 4'(NBYTES));
        w_pulse_err  = w_ss_rise & ~w_pulse_done;
        w_tx_next    = FILL_BYTE;
        if (r_state == S_ACTIVE && r_byte_cnt < 4'(NBYTES-1))
            w_tx_next = frame_byte(r_snap, r_byte_cnt + 4'd1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ss_sync    <= '1;
            r_sclk_sync  <= '0;
            r_mosi_sync  <= '0;
            r_ss_d       <= 1'b1;
            r_sclk_d     <= 1'b0;
            r_snap       <= '0;
            r_tx         <= '0;
            r_rx         <= '0;
            r_bit_cnt    <= '0;
            r_byte_cnt   <= '0;
            r_miso       <= 1'b0;
            r_miso_oe    <= 1'b0;
            r_led        <= 2'b00;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_ss_sync    <= {r_ss_sync[SYNC_STAGES-2:0], spi.ss};
            r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], spi.sclk};
            r_mosi_sync  <= {r_mosi_sync[SYNC_STAGES-2:0], spi.mosi};
            r_ss_d       <= w_ss;
            r_sclk_d     <= w_sclk;
            r_frame_done <= w_pulse_done;
            r_frame_err  <= w_pulse_err;
            if (w_ss_rise) begin
                r_miso    <= 1'b0;
                r_miso_oe <= 1'b0;
            end else if (w_ss_fall) begin
                r_snap     <= {x_pos, y_pos, btn};
                r_tx       <= x_pos[7:0];
                r_miso     <= x_pos[7];
                r_miso_oe  <= 1'b1;
                r_bit_cnt  <= '0;
                r_byte_cnt <= '0;
            end else begin
                if (w_sclk_rise) begin
                    r_rx      <= {r_rx[6:0], w_mosi};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
                if (w_shift) begin
                    r_tx   <= {r_tx[6:0], 1'b0};
                    r_miso <= r_tx[6];
                end
                if (w_byte_done) begin
                    r_bit_cnt  <= '0;
                    r_byte_cnt <= (r_byte_cnt == 4'd15) ? 4'd15 : r_byte_cnt + 4'd1;
                    r_tx       <= w_tx_next;
                    r_miso     <= w_tx_next[7];
                    if (r_byte_cnt == 4'd0 && r_rx[7]) r_led <= r_rx[1:0];
                end
            end
        end
    end

`ifdef JSTK_RESP_ERRCNT_EN
    logic [7:0] r_err_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                            r_err_cnt <= '0;
        else if (w_pulse_err && r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
    end
    assign err_cnt = r_err_cnt;
`endif

    assign spi.miso    = r_miso;
    assign spi.miso_oe = r_miso_oe;
    assign led         = r_led;
    assign frame_done  = r_frame_done;
    assign frame_err   = r_frame_err;

endmodule
